// File: rtl/hazard_scoreboard_if.sv
// Decode-slot / memory-return bundle for the load hazard scoreboard.
// master drives the decode and completion inputs; slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_PENDING    = 4
);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic                      in_id_valid;
  logic [REG_ADDR_WIDTH-1:0] in_id_rs1;
  logic [REG_ADDR_WIDTH-1:0] in_id_rs2;
  logic                      in_id_rs1_used;
  logic                      in_id_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] in_id_rd;
  logic                      in_id_is_load;
  logic                      in_issue;
  logic                      in_mem_done;
  logic [REG_ADDR_WIDTH-1:0] in_mem_done_rd;
  logic                      out_stall;
  logic                      out_id_write;
  logic                      out_pc_write;
  logic [CNT_W-1:0]          out_pending_count;
  logic                      out_full;
  logic                      out_error;
  logic                      out_timeout;

  modport master (
    output in_id_valid, in_id_rs1, in_id_rs2, in_id_rs1_used, in_id_rs2_used,
           in_id_rd, in_id_is_load, in_issue, in_mem_done, in_mem_done_rd,
    input  out_stall, out_id_write, out_pc_write, out_pending_count,
           out_full, out_error, out_timeout
  );

  modport slave (
    input  in_id_valid, in_id_rs1, in_id_rs2, in_id_rs1_used, in_id_rs2_used,
           in_id_rd, in_id_is_load, in_issue, in_mem_done, in_mem_done_rd,
    output out_stall, out_id_write, out_pc_write, out_pending_count,
           out_full, out_error, out_timeout
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-load scoreboard: stalls decode on RAW/WAW against
// in-flight loads or an exhausted load budget, with a stall-run watchdog.
module hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter int MAX_PENDING    = 4,
  parameter int STALL_LIMIT    = 255
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam int WD_W  = $clog2(STALL_LIMIT + 1);

  logic [NUM_REGS-1:0] r_pending;
  logic [CNT_W-1:0]    r_count;
  logic [WD_W-1:0]     r_wd;
  logic                r_error;
  logic                r_timeout;

  logic [NUM_REGS-1:0] w_eff;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic w_rs1_hit, w_rs2_hit, w_rd_hit, w_rd_trk, w_done_pend;
  logic w_full, w_stall, w_load_fire, w_done_ok, w_done_bad;

  // A completion in the current cycle is bypassed, so it masks its own bit.
  always_comb begin
    w_eff       = '0;
    w_rs1_hit   = 1'b0;
    w_rs2_hit   = 1'b0;
    w_rd_hit    = 1'b0;
    w_rd_trk    = 1'b0;
    w_done_pend = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_eff[r] = r_pending[r] &
                 ~(bus.in_mem_done & (bus.in_mem_done_rd == REG_ADDR_WIDTH'(r)));
      if (bus.in_id_rs1 == REG_ADDR_WIDTH'(r)) w_rs1_hit = w_eff[r];
      if (bus.in_id_rs2 == REG_ADDR_WIDTH'(r)) w_rs2_hit = w_eff[r];
      if (bus.in_id_rd == REG_ADDR_WIDTH'(r)) begin
        w_rd_hit = w_eff[r];
        w_rd_trk = 1'b1;
      end
      if (bus.in_mem_done_rd == REG_ADDR_WIDTH'(r)) w_done_pend = r_pending[r];
    end
  end

  assign w_full  = (r_count == CNT_W'(MAX_PENDING));
  assign w_stall = bus.in_id_valid &
                   ((bus.in_id_rs1_used & w_rs1_hit) |
                    (bus.in_id_rs2_used & w_rs2_hit) |
                    (bus.in_id_is_load & w_rd_hit) |
                    (bus.in_id_is_load & w_rd_trk & w_full & ~bus.in_mem_done));

  assign w_load_fire = bus.in_id_valid & bus.in_issue & ~w_stall &
                       bus.in_id_is_load & w_rd_trk;
  assign w_done_ok   = bus.in_mem_done & w_done_pend;
  assign w_done_bad  = bus.in_mem_done & (bus.in_mem_done_rd != '0) & ~w_done_pend;

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    w_pend_nxt = r_pending;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (w_done_ok && (bus.in_mem_done_rd == REG_ADDR_WIDTH'(r))) w_pend_nxt[r] = 1'b0;
      if (w_load_fire && (bus.in_id_rd == REG_ADDR_WIDTH'(r)))     w_pend_nxt[r] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_count   <= '0;
      r_wd      <= '0;
      r_error   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      r_count   <= r_count + CNT_W'(w_load_fire) - CNT_W'(w_done_ok);
      if (w_done_bad) r_error <= 1'b1;
      if (w_stall) begin
        if (r_wd != WD_W'(STALL_LIMIT)) r_wd <= r_wd + WD_W'(1);
        if (r_wd >= WD_W'(STALL_LIMIT - 1)) r_timeout <= 1'b1;
      end else begin
        r_wd <= '0;
      end
    end
  end

  assign bus.out_stall         = w_stall;
  assign bus.out_id_write      = ~w_stall;
  assign bus.out_pc_write      = ~w_stall;
  assign bus.out_pending_count = r_count;
  assign bus.out_full          = w_full;
  assign bus.out_error         = r_error;
  assign bus.out_timeout       = r_timeout;
endmodule
